// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the data stage.
// Optional grant/conflict statistics counters are enabled by defining ARB_STATS_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       if_grant_cnt,
  output logic [15:0]       dm_grant_cnt,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam int unsigned LatW = $clog2(MEM_LAT + 1);
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e           state_q, state_d;
  logic [LatW-1:0]  lat_q;
  logic [StW-1:0]   starve_q;
  logic             owner_fetch_q;
  logic             we_q;
  logic             grant;
  logic             grant_fetch;
  logic             lat_done;

  // Fetch wins only when alone or when data has used up its consecutive-grant allowance.
  assign grant_fetch = if_req & (~dm_req | (starve_q == StW'(STARVE_MAX)));

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    lat_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (if_req || dm_req) begin
          grant   = 1'b1;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (lat_q == LatW'(MEM_LAT)) begin
          lat_done = 1'b1;
          state_d  = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_en = (state_q == StAccess) && (lat_q == '0);
  assign mem_we = mem_en & we_q;
  assign busy   = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      lat_q         <= '0;
      starve_q      <= '0;
      owner_fetch_q <= 1'b0;
      we_q          <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      if_ack        <= 1'b0;
      dm_ack        <= 1'b0;
      if_rdata      <= '0;
      dm_rdata      <= '0;
    end else begin
      state_q <= state_d;
      if_ack  <= 1'b0;
      dm_ack  <= 1'b0;
      if (grant) begin
        owner_fetch_q <= grant_fetch;
        lat_q         <= '0;
        if (grant_fetch) begin
          we_q     <= 1'b0;
          mem_addr <= if_addr;
          starve_q <= '0;
        end else begin
          we_q      <= dm_we;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          starve_q  <= if_req ? starve_q + StW'(1) : '0;
        end
      end
      if ((state_q == StAccess) && !lat_done) begin
        lat_q <= lat_q + LatW'(1);
      end
      if (lat_done) begin
        if (owner_fetch_q) begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          dm_ack <= 1'b1;
          if (!we_q) begin
            dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if_grant_cnt <= '0;
      dm_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else if (grant) begin
      if (grant_fetch && (if_grant_cnt != 16'hFFFF)) begin
        if_grant_cnt <= if_grant_cnt + 16'd1;
      end
      if (!grant_fetch && (dm_grant_cnt != 16'hFFFF)) begin
        dm_grant_cnt <= dm_grant_cnt + 16'd1;
      end
      if (if_req && dm_req && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences and a randomized run
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              if_req, dm_req, dm_we;
  logic [ADDR_W-1:0] if_addr, dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              if_ack, dm_ack, mem_en, mem_we, busy;
  logic [DATA_W-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
`ifdef ARB_STATS_EN
  logic [15:0] if_grant_cnt, dm_grant_cnt, conflict_cnt;
`endif

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_STATS_EN
    , .if_grant_cnt(if_grant_cnt), .dm_grant_cnt(dm_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Memory macro model: writes on strobe, read data valid MEM_LAT cycles later, junk otherwise.
  logic [15:0] mem_arr [256];
  bit          mem_wr  [256];
  logic [15:0] pipe    [MEM_LAT];

  function automatic logic [15:0] dev_read(input logic [15:0] a);
    return mem_wr[a[7:0]] ? mem_arr[a[7:0]] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_addr[7:0]] <= mem_wdata;
      mem_wr[mem_addr[7:0]]  <= 1'b1;
    end
    pipe[0] <= (mem_en && !mem_we) ? dev_read(mem_addr) : 16'($urandom);
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  // Reference model: one transaction at a time, ack MEM_LAT+2 cycles after the grant cycle.
  bit [15:0] ref_mem [256];
  bit        ref_wr  [256];

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_wr[a[7:0]] ? ref_mem[a[7:0]] : init_word(a);
  endfunction

  initial begin : monitor
    int cyc, g_c, a_c, streak;
    bit active, g_fetch, g_we, e_en, e_ack;
    logic [15:0] g_addr, g_wdata, g_rdata, e_if_rd, e_dm_rd;
    cyc = 0; g_c = 0; a_c = 0; streak = 0; active = 0; g_fetch = 0; g_we = 0;
    g_addr = 0; g_wdata = 0; g_rdata = 0; e_if_rd = 0; e_dm_rd = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        active  = 0;
        e_if_rd = 0;
        e_dm_rd = 0;
        streak  = 0;
      end else begin
        e_en  = active && (cyc == g_c + 1);
        e_ack = active && (cyc == a_c);
        check("mem_en", 32'(mem_en), 32'(e_en));
        if (e_en) begin
          check("mem_addr", 32'(mem_addr), 32'(g_addr));
          check("mem_we", 32'(mem_we), 32'(g_we));
          if (g_we) check("mem_wdata", 32'(mem_wdata), 32'(g_wdata));
        end
        check("if_ack", 32'(if_ack), 32'(e_ack && g_fetch));
        check("dm_ack", 32'(dm_ack), 32'(e_ack && !g_fetch));
        if (e_ack && !g_we) begin
          if (g_fetch) e_if_rd = g_rdata;
          else e_dm_rd = g_rdata;
        end
        check("if_rdata", 32'(if_rdata), 32'(e_if_rd));
        check("dm_rdata", 32'(dm_rdata), 32'(e_dm_rd));
        check("busy", 32'(busy), 32'(active && (cyc > g_c)));
        if (e_ack) begin
          active = 0;
        end else if (!active && (if_req || dm_req)) begin
          g_fetch = if_req && (!dm_req || (streak == int'(STARVE_MAX)));
          streak  = (!g_fetch && if_req) ? streak + 1 : 0;
          g_addr  = g_fetch ? if_addr : dm_addr;
          g_we    = !g_fetch && dm_we;
          g_wdata = dm_wdata;
          g_rdata = ref_read(g_addr);
          if (g_we) begin
            ref_mem[g_addr[7:0]] = g_wdata;
            ref_wr[g_addr[7:0]]  = 1'b1;
          end
          g_c    = cyc;
          a_c    = cyc + int'(MEM_LAT) + 2;
          active = 1;
        end
      end
    end
  end

  typedef struct packed {
    logic        ifr;
    logic [15:0] ia;
    logic        dmr;
    logic        we;
    logic [15:0] da;
    logic [15:0] wd;
    logic        exp_f;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [9];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin : main
    int lat, n;
    logic [9:0] order;

    tbl[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
    tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000};
    tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1234};
    tbl[3] = '{1'b1, 16'h0100, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h5A6A};
    tbl[4] = '{1'b1, 16'h0100, 1'b1, 1'b1, 16'h0031, 16'hABCD, 1'b0, 16'h5A6A};
    tbl[5] = '{1'b1, 16'h0100, 1'b1, 1'b0, 16'h0031, 16'h0000, 1'b0, 16'hABCD};
    tbl[6] = '{1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h5A5A};
    tbl[7] = '{1'b1, 16'h0040, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5A1A};
    tbl[8] = '{1'b1, 16'h0040, 1'b1, 1'b0, 16'h0031, 16'h0000, 1'b0, 16'hABCD};

    // Reset held two cycles with both requests high.
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; if_addr = '0;
    dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    step(); step();
    check("rst_if_ack", 32'(if_ack), 0);
    check("rst_dm_ack", 32'(dm_ack), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_if_rdata", 32'(if_rdata), 0);
    check("rst_dm_rdata", 32'(dm_rdata), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    step();

    // Single transactions from IDLE.
    for (int r = 0; r < 9; r++) begin
      if_req = tbl[r].ifr; if_addr = tbl[r].ia;
      dm_req = tbl[r].dmr; dm_we = tbl[r].we; dm_addr = tbl[r].da; dm_wdata = tbl[r].wd;
      lat = 0;
      for (int c = 0; c < 20; c++) begin
        step();
        lat++;
        if (if_ack || dm_ack) break;
      end
      check("vec_latency", 32'(lat), 32'(MEM_LAT + 2));
      check("vec_owner", 32'(if_ack), 32'(tbl[r].exp_f));
      check("vec_one_ack", 32'(if_ack && dm_ack), 0);
      check("vec_rdata", 32'(tbl[r].exp_f ? if_rdata : dm_rdata), 32'(tbl[r].exp_rd));
      if_req = 1'b0; dm_req = 1'b0;
      step();
    end

    // Randomized traffic; the monitor judges every cycle.
    for (int c = 0; c < 3000; c++) begin
      if (if_req && if_ack) if_req = 1'b0;
      else if (!if_req && ($urandom_range(0, 2) == 0)) begin
        if_req = 1'b1; if_addr = 16'($urandom_range(0, 15));
      end
      if (dm_req && dm_ack) dm_req = 1'b0;
      else if (!dm_req && ($urandom_range(0, 2) == 0)) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 16'($urandom_range(0, 15)); dm_wdata = 16'($urandom);
      end
      step();
    end
    if_req = 1'b0; dm_req = 1'b0;
    for (int c = 0; c < 20 && busy; c++) step();
    check("drain_idle", 32'(busy), 0);

    // Both requests held continuously from a fresh reset.
    rst = 1'b1; step(); rst = 1'b0;
    if_req = 1'b1; if_addr = 16'h0050; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0005;
    n = 0; order = '0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      step();
      if (if_ack || dm_ack) begin
        order = {order[8:0], if_ack};
        n++;
      end
    end
    check("starve_grants", 32'(n), 10);
    check("starve_order", 32'(order), 32'(10'b0000100001));
`ifdef ARB_STATS_EN
    check("stat_dm", 32'(dm_grant_cnt), 8);
    check("stat_if", 32'(if_grant_cnt), 2);
    check("stat_conflict", 32'(conflict_cnt), 10);
`endif
    if_req = 1'b0; dm_req = 1'b0;
    for (int c = 0; c < 20 && busy; c++) step();
    step();

    // Request inputs change mid-access: the latched read of 0x0020 must still complete.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0020;
    step();
    dm_addr = 16'h0031; dm_we = 1'b1; dm_wdata = 16'hDEAD; if_req = 1'b1;
    lat = 1;
    for (int c = 0; c < 20 && !(if_ack || dm_ack); c++) begin
      step();
      lat++;
    end
    check("hold_latency", 32'(lat), 32'(MEM_LAT + 2));
    check("hold_dm_ack", 32'(dm_ack), 1);
    check("hold_rdata", 32'(dm_rdata), 32'h1234);
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    step();

    // Reset during the ACCESS phase of a data read abandons it.
    dm_req = 1'b1; dm_addr = 16'h0020;
    step(); step();
    check("mid_busy_before", 32'(busy), 1);
    rst = 1'b1; dm_req = 1'b0;
    step();
    rst = 1'b0;
    check("mid_busy", 32'(busy), 0);
    check("mid_dm_ack", 32'(dm_ack), 0);
    check("mid_dm_rdata", 32'(dm_rdata), 0);
    for (int c = 0; c < 6; c++) begin
      step();
      check("mid_no_ack", 32'(dm_ack || if_ack), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
